data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port word memory with byte enables and a 1- or 2-cycle read pipeline.
// Define DATA_MEM_CLEAR_EN to compile in the post-reset zero-fill sweep.
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_RST = 2'd0,
    S_RUN = 2'd2
  } state_t;
`endif

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic acc;
  logic acc_wr;
  logic acc_rd;

  logic              rd_v1;
  logic [DATA_W-1:0] rd_d1;

  assign req_ready = (state == S_RUN);
  assign acc       = req_valid & req_ready;
  assign acc_wr    = acc & req_we;
  assign acc_rd    = acc & ~req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      state <= state_nx;
    end
  end

`ifdef DATA_MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  assign busy = (state == S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (busy) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:   state_nx = S_CLEAR;
      S_CLEAR: if (&clr_cnt) state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_RST;
    endcase
  end
`else
  assign busy = 1'b0;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:   state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_RST;
    endcase
  end
`endif

  // Storage is never reset; only the sweep (when built in) zeroes it.
  always_ff @(posedge clk) begin
`ifdef DATA_MEM_CLEAR_EN
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else
`endif
    if (acc_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else begin
      rd_v1 <= acc_rd;
      if (acc_rd) begin
        rd_d1 <= mem[req_addr];
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rsp_valid = rd_v1;
      assign rsp_rdata = rd_d1;
    end else begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) begin
            rd_d2 <= rd_d1;
          end
        end
      end

      assign rsp_valid = rd_v2;
      assign rsp_rdata = rd_d2;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks on three data_mem_ctrl configurations.
// Covers reset, clear sweep (DATA_MEM_CLEAR_EN), byte enables, latency, streaming.
module tb_data_mem_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  // a: 8-bit x 256, RD_LAT=1
  logic       a_valid, a_ready, a_we, a_rsp_valid, a_busy;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic [0:0] a_be;
  // b: 32-bit x 16, RD_LAT=1
  logic        b_valid, b_ready, b_we, b_rsp_valid, b_busy;
  logic [3:0]  b_addr, b_be;
  logic [31:0] b_wdata, b_rdata;
  // c: 8-bit x 16, RD_LAT=2
  logic       c_valid, c_ready, c_we, c_rsp_valid, c_busy;
  logic [3:0] c_addr;
  logic [7:0] c_wdata, c_rdata;
  logic [0:0] c_be;

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy)
  );

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy)
  );

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_ready(c_ready),
    .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_chk++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    n_chk++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", a_rsp_valid); end
    n_chk++; if (a_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", a_rdata); end
    n_chk++; if (c_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c_rsp_valid: got %b want 0", c_rsp_valid); end
    n_chk++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_b_rdata: got %h want 0", b_rdata); end
    rst_n = 1'b1;
    tick;
`ifdef DATA_MEM_CLEAR_EN
    n_chk++; if ({c_busy, c_ready} !== 2'b10) begin n_fail++; $display("FAIL first_edge_clear: busy,ready got %b want 10", {c_busy, c_ready}); end
`else
    n_chk++; if ({a_busy, a_ready} !== 2'b01) begin n_fail++; $display("FAIL first_edge_run: busy,ready got %b want 01", {a_busy, a_ready}); end
    n_chk++; if ({c_busy, c_ready} !== 2'b01) begin n_fail++; $display("FAIL first_edge_run_c: busy,ready got %b want 01", {c_busy, c_ready}); end
`endif
  endtask

`ifdef DATA_MEM_CLEAR_EN
  // Called one sample after the first sweep edge; checks the remaining 15 busy cycles.
  task automatic check_sweep_c(input string tag);
    c_valid = 1'b1; c_we = 1'b1; c_addr = 4'h5; c_wdata = 8'hFF; c_be = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick;
      n_chk++; if ({c_busy, c_ready} !== 2'b10) begin n_fail++; $display("FAIL %s_busy[%0d]: busy,ready got %b want 10", tag, i, {c_busy, c_ready}); end
    end
    c_valid = 1'b0;
    tick;
    n_chk++; if ({c_busy, c_ready} !== 2'b01) begin n_fail++; $display("FAIL %s_done: busy,ready got %b want 01", tag, {c_busy, c_ready}); end
  endtask

  task automatic wait_a_idle;
    int k;
    k = 0;
    while (a_busy && k < 400) begin tick; k++; end
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL a_sweep_timeout: busy got %b want 0", a_busy); end
  endtask

  task automatic test_clear;
    check_sweep_c("sweep");
    for (int i = 0; i < 16; i++) begin
      c_valid = 1'b1; c_we = 1'b0; c_addr = 4'(i);
      tick;
      c_valid = 1'b0;
      tick;
      n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h100) begin n_fail++; $display("FAIL clear_read[%0d]: valid,data got %b,%h want 1,00", i, c_rsp_valid, c_rdata); end
    end
    wait_a_idle;
  endtask
`endif

  task automatic test_write_read;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h3C; a_wdata = 8'hA5; a_be = 1'b1;
    tick;
    n_chk++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", a_rsp_valid); end
    a_we = 1'b0;
    tick;
    n_chk++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", a_rsp_valid); end
    n_chk++; if (a_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", a_rdata); end
    a_valid = 1'b0;
    tick;
    n_chk++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got %b want 0", a_rsp_valid); end
    n_chk++; if (a_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: got %h want a5", a_rdata); end
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h00; a_wdata = 8'h5A;
    tick;
    a_we = 1'b0;
    tick;
    n_chk++; if ({a_rsp_valid, a_rdata} !== 9'h15A) begin n_fail++; $display("FAIL rd_addr0: valid,data got %b,%h want 1,5a", a_rsp_valid, a_rdata); end
    a_valid = 1'b0;
    tick;
  endtask

  task automatic test_byte_enable;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h7; b_wdata = 32'h11223344; b_be = 4'hF;
    tick;
    b_wdata = 32'hAABBCCDD; b_be = 4'h5;
    tick;
    b_wdata = 32'hFFFFFFFF; b_be = 4'h0;
    tick;
    b_we = 1'b0;
    tick;
    n_chk++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL be_valid: got %b want 1", b_rsp_valid); end
    n_chk++; if (b_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_data: got %h want 11bb33dd", b_rdata); end
    b_valid = 1'b0;
    tick;
    n_chk++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL be_pulse: got %b want 0", b_rsp_valid); end
  endtask

  task automatic test_streaming;
    c_valid = 1'b1; c_we = 1'b1; c_be = 1'b1;
    c_addr = 4'h1; c_wdata = 8'h51;
    tick;
    c_addr = 4'h2; c_wdata = 8'h52;
    tick;
    c_addr = 4'h3; c_wdata = 8'h53;
    tick;
    c_we = 1'b0; c_addr = 4'h1;
    tick;
    n_chk++; if (c_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_lat: got %b want 0", c_rsp_valid); end
    c_addr = 4'h2;
    tick;
    n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h151) begin n_fail++; $display("FAIL stream_0: valid,data got %b,%h want 1,51", c_rsp_valid, c_rdata); end
    c_addr = 4'h3;
    tick;
    n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h152) begin n_fail++; $display("FAIL stream_1: valid,data got %b,%h want 1,52", c_rsp_valid, c_rdata); end
    c_valid = 1'b0;
    tick;
    n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h153) begin n_fail++; $display("FAIL stream_2: valid,data got %b,%h want 1,53", c_rsp_valid, c_rdata); end
    tick;
    n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h053) begin n_fail++; $display("FAIL stream_end: valid,data got %b,%h want 0,53", c_rsp_valid, c_rdata); end
  endtask

  task automatic test_back_to_back;
    a_valid = 1'b1; a_we = 1'b1; a_be = 1'b1;
    a_addr = 8'h10; a_wdata = 8'h01;
    tick;
    a_addr = 8'h11; a_wdata = 8'h02;
    tick;
    a_we = 1'b0; a_addr = 8'h10;
    tick;
    n_chk++; if ({a_rsp_valid, a_rdata} !== 9'h101) begin n_fail++; $display("FAIL b2b_0: valid,data got %b,%h want 1,01", a_rsp_valid, a_rdata); end
    a_addr = 8'h11;
    tick;
    n_chk++; if ({a_rsp_valid, a_rdata} !== 9'h102) begin n_fail++; $display("FAIL b2b_1: valid,data got %b,%h want 1,02", a_rsp_valid, a_rdata); end
    a_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 4'h1;
    tick;
    c_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({c_rsp_valid, c_rdata} !== 9'h000) begin n_fail++; $display("FAIL mid_rst_out: valid,data got %b,%h want 0,00", c_rsp_valid, c_rdata); end
    tick;
    #4;
    rst_n = 1'b1;
    tick;
`ifdef DATA_MEM_CLEAR_EN
    n_chk++; if ({c_busy, c_ready, c_rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_restart: busy,ready,valid got %b want 100", {c_busy, c_ready, c_rsp_valid}); end
    for (int i = 1; i < 10; i++) tick;
    rst_n = 1'b0;
    #1;
    n_chk++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_rst_busy: got %b want 0", c_busy); end
    #3;
    rst_n = 1'b1;
    tick;
    n_chk++; if ({c_busy, c_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_sweep_restart: busy,ready got %b want 10", {c_busy, c_ready}); end
    check_sweep_c("resweep");
    n_chk++; if (c_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b want 0", c_rsp_valid); end
    wait_a_idle;
`else
    n_chk++; if ({c_ready, c_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL mid_restart: ready,valid got %b want 10", {c_ready, c_rsp_valid}); end
    a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h3C;
    tick;
    n_chk++; if ({a_rsp_valid, a_rdata} !== 9'h1A5) begin n_fail++; $display("FAIL mem_kept: valid,data got %b,%h want 1,a5", a_rsp_valid, a_rdata); end
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if (c_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", i, c_rsp_valid); end
    end
`endif
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
    test_reset;
`ifdef DATA_MEM_CLEAR_EN
    test_clear;
`endif
    test_write_read;
    test_byte_enable;
    test_streaming;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
